dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences the data-memory access of the MEM stage of the 5-stage MIPS pipeline against a variable-latency memory with a req/ready handshake. It holds the instruction in MEM (StallM) until the access completes. It injects a bubble into the MEM/WB pipeline register (FlushW) while stalled. It presents the captured load data on ReadDataM in the completion cycle and aborts hung accesses with a timeout.

Parameters:
TIMEOUT, 15, max cycles spent in REQ before abort; 0 disables timeout
CNT_W, 4, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
MemReadM  in  1  load instruction in MEM stage
MemWriteM  in  1  store instruction in MEM stage
ALUOutM  in  32  byte address from EX/MEM register
WriteDataM  in  32  store data from EX/MEM register
ReadDataM  out  32  load data toward MEM/WB register; valid in DONE
StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM registers
FlushW  out  1  load a bubble (all zero) into MEM/WB register
BusErrM  out  1  one-cycle pulse: access aborted (timeout or misaligned)
mem_req  out  1  registered request to data memory
mem_we  out  1  registered write enable, valid with mem_req
mem_addr  out  32  registered word address, valid with mem_req
mem_wdata  out  32  registered store data, valid with mem_req
mem_rdata  in  32  read data, sampled when mem_ready=1 in REQ
mem_ready  in  1  memory completion, sampled only in REQ

Behaviour:
- Reset: clk and rst only; synchronous active-high. While rst=1, StallM=0 and FlushW=0. The edge with rst=1 sets state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_q=0, cnt=0, BusErrM=0.
- Reset mid-access drops mem_req at that edge. The memory must tolerate request withdrawal.
- access = MemReadM | MemWriteM. If both are 1, the access is a write; no data is captured.
- FSM states: IDLE, REQ, DONE.
- IDLE, access=0: StallM=0, FlushW=0; state stays IDLE.
- IDLE, access=1, ALUOutM[1:0]==0: StallM=1, FlushW=1. Next edge latches mem_addr=ALUOutM, mem_wdata=WriteDataM, mem_we=MemWriteM, mem_req=1, cnt=0, state->REQ.
- IDLE, access=1, ALUOutM[1:0]!=0 (misaligned): StallM=1, FlushW=1, no request. Next edge sets BusErrM=1, rdata_q=0, state->DONE.
- REQ: StallM=1, FlushW=1.
  - mem_ready=1: next edge mem_req=0, rdata_q=mem_rdata (reads only), state->DONE.
  - mem_ready=0, TIMEOUT!=0, cnt==TIMEOUT-1: next edge mem_req=0, BusErrM=1, rdata_q=0, state->DONE.
  - Otherwise cnt increments.
- DONE: StallM=0, FlushW=0, ReadDataM=rdata_q. The pipeline advances at this edge. BusErrM (set at entry) clears at the DONE->IDLE edge. Next edge state->IDLE.
- ReadDataM = rdata_q in all states; it holds the last value.
- Latency: zero-wait memory (ready in first REQ cycle) costs 2 stall cycles per access. Each extra wait state adds 1.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE. There is no idle gap on the memory bus beyond that cycle.
- mem_ready outside REQ is ignored. mem_rdata is don't-care outside REQ.
- StallM and FlushW are combinational from state and inputs. Every other output is registered.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the alignment mask constant.
- No sub-module. FSM, timeout counter and capture register live in one module of about 150-200 lines.

Test Plan:
- Load, zero wait: MemReadM=1, ALUOutM=0x100, mem_ready=1 in first REQ cycle with mem_rdata=0xCAFEF00D.
  - mem_req high 1 cycle, mem_addr=0x100, mem_we=0.
  - StallM=1 for 2 cycles, then DONE with ReadDataM=0xCAFEF00D, StallM=0.
- Store, 3 wait states: MemWriteM=1, ALUOutM=0x20, WriteDataM=0x12345678.
  - mem_we=1 and mem_wdata=0x12345678 for 4 REQ cycles.
  - StallM=1 and FlushW=1 for 5 cycles.
  - ReadDataM unchanged.
- Timeout: TIMEOUT=4, load, mem_ready never asserted.
  - mem_req high exactly 4 cycles.
  - BusErrM=1 for exactly 1 cycle, in DONE; ReadDataM=0.
- Misaligned: MemReadM=1, ALUOutM=0x102.
  - No mem_req.
  - 1 stall cycle, then DONE with BusErrM=1.
- Back-to-back, then reset mid-access:
  - Load then store in consecutive instructions: two complete handshakes, second mem_req rises 2 cycles after first DONE.
  - rst=1 during REQ: mem_req=0 after that edge, state IDLE, StallM=0.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Holds the FSM state encoding and the word-alignment helper.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    localparam logic [1:0] AlignMask = 2'b11;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] & AlignMask) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: stalls the pipeline while a load/store runs
// against a req/ready memory, captures load data, and aborts misaligned or hung accesses.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FlushW,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam bit             TimeoutEn = (TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] CntLast =
        CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             berr_q, berr_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic access;
    logic timeout_hit;

    assign access      = MemReadM | MemWriteM;
    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        berr_d  = berr_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        StallM  = 1'b0;
        FlushW  = 1'b0;

        case (state_q)
            StIdle: begin
                if (access) begin
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (is_word_aligned(ALUOutM)) begin
                        addr_d  = ALUOutM;
                        wdata_d = WriteDataM;
                        we_d    = MemWriteM;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StReq;
                    end else begin
                        berr_d  = 1'b1;
                        rdata_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                StallM = 1'b1;
                FlushW = 1'b1;
                if (mem_ready) begin
                    req_d = 1'b0;
                    // A write (including read+write) leaves the last load data in place.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                berr_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The pipeline must not be frozen while reset is being applied.
        if (rst) begin
            StallM = 1'b0;
            FlushW = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ReadDataM = rdata_q;
    assign BusErrM   = berr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus random accesses
// checked against a per-transaction model of stall length, handshake and load data.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, FlushW, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_rd;
    int done_cyc;
    int first_req_cyc;

    dmem_access_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .StallM    (StallM),
        .FlushW    (FlushW),
        .BusErrM   (BusErrM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MemReadM   = 1'b0;
            MemWriteM  = 1'b0;
            ALUOutM    = $urandom;
            WriteDataM = $urandom;
            mem_ready  = 1'($urandom);
            mem_rdata  = $urandom;
            #1;
            check("idle_stall", {31'b0, StallM}, 32'd0);
            check("idle_flush", {31'b0, FlushW}, 32'd0);
            check("idle_req", {31'b0, mem_req}, 32'd0);
            check("idle_berr", {31'b0, BusErrM}, 32'd0);
            check("idle_rdata", ReadDataM, last_rd);
        end
    endtask

    // One instruction in MEM: the memory answers after `waits` not-ready REQ cycles.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata_in);
        bit          misal;
        bit          err;
        int          n_req;
        int          stalls;
        int          req_cycles;
        int          exp_stalls;
        logic [31:0] new_rd;
        bit          in_req, done, rdy;

        misal = (addr[1:0] != 2'b00);
        if (misal) begin
            n_req = 0; err = 1'b1; new_rd = '0; exp_stalls = 1;
        end else if (waits >= int'(TO)) begin
            n_req = TO; err = 1'b1; new_rd = '0; exp_stalls = TO + 1;
        end else begin
            n_req = waits + 1; err = 1'b0; exp_stalls = waits + 2;
            new_rd = (rd && !wr) ? rdata_in : last_rd;
        end
        stalls = 0;
        req_cycles = 0;
        first_req_cyc = -1;

        for (int k = 0; k <= n_req + 1; k++) begin
            in_req = (k >= 1) && (k <= n_req);
            done   = (k == n_req + 1);
            rdy    = in_req && (k - 1 == waits);
            @(negedge clk);
            MemReadM   = rd;
            MemWriteM  = wr;
            ALUOutM    = addr;
            WriteDataM = wdata;
            mem_ready  = in_req ? rdy : 1'($urandom);
            mem_rdata  = rdy ? rdata_in : $urandom;
            #1;
            if (StallM) stalls++;
            if (mem_req) begin
                req_cycles++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            check("stall", {31'b0, StallM}, {31'b0, !done});
            check("flush", {31'b0, FlushW}, {31'b0, !done});
            check("req", {31'b0, mem_req}, {31'b0, in_req});
            check("berr", {31'b0, BusErrM}, {31'b0, done && err});
            check("rdata", ReadDataM, done ? new_rd : last_rd);
            if (in_req) begin
                check("addr", mem_addr, addr);
                check("we", {31'b0, mem_we}, {31'b0, wr});
                check("wdata", mem_wdata, wdata);
            end
        end
        check("stall_len", stalls, exp_stalls);
        check("req_len", req_cycles, n_req);
        last_rd = new_rd;
    endtask

    initial begin
        int          d1;
        logic        rd, wr;
        logic [31:0] a;

        rst        = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        last_rd    = '0;
        done_cyc   = 0;

        // Reset state, including an access presented while reset is held.
        repeat (2) @(negedge clk);
        MemReadM = 1'b1;
        #1;
        check("rst_stall", {31'b0, StallM}, 32'd0);
        check("rst_flush", {31'b0, FlushW}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_berr", {31'b0, BusErrM}, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        MemReadM = 1'b0;
        idle(2);

        // Zero-wait load.
        access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D);
        idle(1);
        // Store with 3 wait states; load data must survive.
        access(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'hDEADBEEF);
        idle(1);
        // Hung load aborts after TO request cycles.
        access(1'b1, 1'b0, 32'h40, 32'h0, 100, 32'h0);
        idle(1);
        // Misaligned load.
        access(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h55555555);
        idle(1);
        // Read+write together behaves as a write.
        access(1'b1, 1'b0, 32'h8, 32'h0, 1, 32'hA5A5A5A5);
        access(1'b1, 1'b1, 32'hC, 32'h77, 0, 32'h11111111);

        // Back-to-back load then store.
        access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h0BADCAFE);
        d1 = done_cyc;
        access(1'b0, 1'b1, 32'h204, 32'hFEEDFACE, 0, 32'h0);
        check("b2b_gap", first_req_cyc - d1, 32'd2);

        // Reset in the middle of a request.
        @(negedge clk);
        MemReadM  = 1'b1;
        MemWriteM = 1'b0;
        ALUOutM   = 32'h300;
        mem_ready = 1'b0;
        #1;
        check("mid_idle_stall", {31'b0, StallM}, 32'd1);
        @(negedge clk);
        #1;
        check("mid_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", {31'b0, StallM}, 32'd0);
        check("mid_rst_flush", {31'b0, FlushW}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        MemReadM = 1'b0;
        #1;
        check("post_rst_req", {31'b0, mem_req}, 32'd0);
        check("post_rst_stall", {31'b0, StallM}, 32'd0);
        check("post_rst_rdata", ReadDataM, 32'd0);
        last_rd = '0;
        access(1'b1, 1'b0, 32'h304, 32'h0, 0, 32'h13579BDF);

        // Random accesses, including timeouts and misalignment.
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            access(rd, wr, a, $urandom, $urandom_range(0, 5), $urandom);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
